// File: rtl/spr_line_render.sv
// Sprite line renderer: scans attribute RAM for sprites on the next line,
// fetches 4bpp pattern row halves and writes opaque pixels to the line buffer.
module spr_line_render #(
  parameter int NSPR   = 64,
  parameter int MAXSPR = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        line_start,
  input  logic [7:0]  vpos,
  output logic [9:0]  sa_adr,
  input  logic [15:0] sa_dat,
  output logic        rom_req,
  output logic [12:0] rom_adr,
  input  logic        rom_ack,
  input  logic [31:0] rom_dat,
  output logic [9:0]  lb_wadr,
  output logic [10:0] lb_wdat,
  output logic        lb_we,
  output logic        busy,
  output logic        ovf
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SC0   = 3'd1;
  localparam logic [2:0] S_SC1   = 3'd2;
  localparam logic [2:0] S_AT0   = 3'd3;
  localparam logic [2:0] S_AT1   = 3'd4;
  localparam logic [2:0] S_FETCH = 3'd5;
  localparam logic [2:0] S_DRAW  = 3'd6;
  localparam logic [2:0] S_DONE  = 3'd7;

  localparam int         CW      = $clog2(MAXSPR + 1);
  localparam logic [9:0] NSPR_L  = 10'(NSPR);
  localparam logic [CW-1:0] MAX_L = CW'(MAXSPR);

  logic [2:0]    state;
  logic [8:0]    idx;
  logic [CW-1:0] cnt;
  logic          bank;
  logic [3:0]    row;
  logic [8:0]    xpos;
  logic [6:0]    pal;
  logic          half;
  logic [2:0]    pix_idx;
  logic [27:0]   pix_sr;
  logic [8:0]    xcur;

  logic [7:0]    row_s;
  logic          hit_s;
  logic          term_s;
  logic [8:0]    idx_nxt_s;
  logic          last_s;
  logic [8:0]    base_x_s;

  // Hit test and slot bookkeeping derived from the current attribute word.
  always_comb begin
    row_s     = vpos - sa_dat[15:8];
    hit_s     = (row_s[7:4] == 4'd0);
    term_s    = (sa_dat[15:8] == 8'hE0);
    idx_nxt_s = idx + 9'd1;
    last_s    = (({1'b0, idx} + 10'd1) == NSPR_L);
    base_x_s  = xpos + {5'd0, half, 3'd0};
  end

  // Main render FSM; line_start restarts from any state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      idx     <= 9'd0;
      cnt     <= '0;
      bank    <= 1'b0;
      row     <= 4'd0;
      xpos    <= 9'd0;
      pal     <= 7'd0;
      half    <= 1'b0;
      pix_idx <= 3'd0;
      pix_sr  <= 28'd0;
      xcur    <= 9'd0;
      sa_adr  <= 10'd0;
      rom_req <= 1'b0;
      rom_adr <= 13'd0;
      lb_wadr <= 10'd0;
      lb_wdat <= 11'd0;
      lb_we   <= 1'b0;
      busy    <= 1'b0;
      ovf     <= 1'b0;
    end else if (line_start) begin
      bank    <= ~bank;
      idx     <= 9'd0;
      cnt     <= '0;
      ovf     <= 1'b0;
      busy    <= 1'b1;
      sa_adr  <= 10'd0;
      rom_req <= 1'b0;
      lb_we   <= 1'b0;
      state   <= S_SC0;
    end else begin
      lb_we <= 1'b0;
      case (state)
        S_IDLE: state <= S_IDLE;
        S_SC0:  state <= S_SC1;
        S_SC1: begin
          if (term_s) begin
            state <= S_DONE;
          end else if (!hit_s) begin
            if (last_s) begin
              state <= S_DONE;
            end else begin
              idx    <= idx_nxt_s;
              sa_adr <= {idx_nxt_s, 1'b0};
              state  <= S_SC0;
            end
          end else if (cnt == MAX_L) begin
            ovf   <= 1'b1;
            state <= S_DONE;
          end else begin
            row        <= row_s[3:0];
            xpos[7:0]  <= sa_dat[7:0];
            cnt        <= cnt + CW'(1);
            sa_adr     <= {idx, 1'b1};
            state      <= S_AT0;
          end
        end
        S_AT0: state <= S_AT1;
        S_AT1: begin
          xpos[8] <= sa_dat[15];
          pal     <= sa_dat[14:8];
          half    <= 1'b0;
          rom_adr <= {sa_dat[7:0], row, 1'b0};
          state   <= S_FETCH;
        end
        S_FETCH: begin
          if (rom_req && rom_ack) begin
            // First pixel is registered straight from the ack so lb_we
            // lines up with the eight DRAW cycles.
            rom_req <= 1'b0;
            pix_sr  <= rom_dat[27:0];
            pix_idx <= 3'd0;
            xcur    <= base_x_s;
            lb_we   <= (rom_dat[31:28] != 4'd0);
            lb_wadr <= {bank, base_x_s};
            lb_wdat <= {pal, rom_dat[31:28]};
            state   <= S_DRAW;
          end else begin
            rom_req <= 1'b1;
          end
        end
        S_DRAW: begin
          if (pix_idx != 3'd7) begin
            pix_idx <= pix_idx + 3'd1;
            pix_sr  <= {pix_sr[23:0], 4'd0};
            xcur    <= xcur + 9'd1;
            lb_we   <= (pix_sr[27:24] != 4'd0);
            lb_wadr <= {bank, xcur + 9'd1};
            lb_wdat <= {pal, pix_sr[27:24]};
          end else if (!half) begin
            half       <= 1'b1;
            rom_adr[0] <= 1'b1;
            state      <= S_FETCH;
          end else if (last_s) begin
            state <= S_DONE;
          end else begin
            idx    <= idx_nxt_s;
            sa_adr <= {idx_nxt_s, 1'b0};
            state  <= S_SC0;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spr_line_render.sv
// Scoreboard bench for spr_line_render: a behavioural line model pushes the
// expected ROM addresses and line-buffer writes, a monitor pops and compares.
module tb_spr_line_render;

  localparam int NSPR   = 64;
  localparam int MAXSPR = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        line_start = 1'b0;
  logic [7:0]  vpos = 8'd0;
  logic [9:0]  sa_adr;
  logic [15:0] sa_dat;
  logic        rom_req;
  logic [12:0] rom_adr;
  logic        rom_ack;
  logic [31:0] rom_dat;
  logic [9:0]  lb_wadr;
  logic [10:0] lb_wdat;
  logic        lb_we;
  logic        busy;
  logic        ovf;

  spr_line_render #(.NSPR(NSPR), .MAXSPR(MAXSPR)) dut (
    .clk(clk), .rst_n(rst_n), .line_start(line_start), .vpos(vpos),
    .sa_adr(sa_adr), .sa_dat(sa_dat), .rom_req(rom_req), .rom_adr(rom_adr),
    .rom_ack(rom_ack), .rom_dat(rom_dat), .lb_wadr(lb_wadr), .lb_wdat(lb_wdat),
    .lb_we(lb_we), .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [15:0] ram [0:1023];
  logic [11:0] lbuf [0:1023];
  logic [20:0] wq[$];
  logic [12:0] rq[$];
  logic        exp_bank = 1'b0;
  int          rom_mode = 0;
  int          ack_dly = 3;
  logic        resp_en = 1'b1;
  logic        late_ack = 1'b0;
  int          wr_seen = 0;
  logic        req_prev = 1'b0;
  logic [12:0] adr_prev = 13'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] rom_fn(input logic [12:0] a);
    if (rom_mode == 0) return 32'h1234_0567;
    else return 32'h1230_4507 ^ {3'd0, a, 3'd0, a[12:0]};
  endfunction

  // synchronous attribute RAM
  always @(posedge clk) sa_dat <= ram[sa_adr];

  // pattern ROM responder
  initial begin
    rom_ack = 1'b0;
    rom_dat = 32'd0;
    forever begin
      @(posedge clk); #1;
      if (late_ack) begin
        rom_ack = 1'b1; rom_dat = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        rom_ack = 1'b0; late_ack = 1'b0;
      end else if (resp_en && rom_req && rst_n) begin
        repeat (ack_dly) @(posedge clk);
        #1;
        rom_ack = 1'b1; rom_dat = rom_fn(rom_adr);
        @(posedge clk); #1;
        rom_ack = 1'b0;
      end
    end
  end

  // monitor: compare writes and fetch addresses against the scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (lb_we) begin
        wr_seen++;
        lbuf[lb_wadr] = {1'b0, lb_wdat};
        if (wq.size() == 0) chk("wr_unexp", {11'd0, lb_wadr, lb_wdat}, 32'd0);
        else chk("wr", {11'd0, lb_wadr, lb_wdat}, {11'd0, wq.pop_front()});
      end
      if (rom_req && !req_prev) begin
        if (rq.size() == 0) chk("rom_unexp", {19'd0, rom_adr}, 32'd0);
        else chk("rom_adr", {19'd0, rom_adr}, {19'd0, rq.pop_front()});
      end
      if (rom_req && req_prev && rom_adr != adr_prev)
        chk("rom_adr_stable", {19'd0, rom_adr}, {19'd0, adr_prev});
      req_prev = rom_req;
      adr_prev = rom_adr;
    end else begin
      req_prev = 1'b0;
    end
  end

  // behavioural line model; returns expected ovf
  function automatic logic model_line(input logic [7:0] v);
    int c = 0;
    logic [15:0] w0, w1;
    logic [7:0] r;
    logic [8:0] x, xp;
    logic [12:0] a;
    logic [31:0] d;
    logic [3:0] pix;
    for (int n = 0; n < NSPR; n++) begin
      w0 = ram[2*n];
      if (w0[15:8] == 8'hE0) return 1'b0;
      r = v - w0[15:8];
      if (r < 8'd16) begin
        if (c == MAXSPR) return 1'b1;
        c++;
        w1 = ram[2*n+1];
        x = {w1[15], w0[7:0]};
        for (int h = 0; h < 2; h++) begin
          a = {w1[7:0], r[3:0], h[0]};
          rq.push_back(a);
          d = rom_fn(a);
          for (int p = 0; p < 8; p++) begin
            pix = d[31-4*p -: 4];
            xp = x + 9'(8*h + p);
            if (pix != 4'd0) wq.push_back({exp_bank, xp, w1[14:8], pix});
          end
        end
      end
    end
    return 1'b0;
  endfunction

  task automatic set_spr(input int n, input logic [7:0] yt, input logic [8:0] x,
                         input logic [6:0] pal, input logic [7:0] code);
    ram[2*n]   = {yt, x[7:0]};
    ram[2*n+1] = {x[8], pal, code};
  endtask

  task automatic clear_all();
    for (int k = 0; k < 1024; k++) begin
      ram[k] = 16'hE000;
      lbuf[k] = 12'hFFF;
    end
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk("busy_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic run_line(input logic [7:0] v, input int exp_lat);
    logic eo;
    int n;
    exp_bank = ~exp_bank;
    eo = model_line(v);
    for (int k = 0; k < 1024; k++) lbuf[k] = 12'hFFF;
    wr_seen = 0;
    @(negedge clk); vpos = v; line_start = 1'b1;
    @(negedge clk); line_start = 1'b0;
    chk("start_sa_adr", {22'd0, sa_adr}, 32'd0);
    chk("start_busy", {31'd0, busy}, 32'd1);
    chk("start_ovf", {31'd0, ovf}, 32'd0);
    wait_idle(n);
    if (exp_lat >= 0) chk("busy_latency", n, exp_lat);
    chk("ovf", {31'd0, ovf}, {31'd0, eo});
    chk("wr_left", wq.size(), 0);
    chk("rom_left", rq.size(), 0);
  endtask

  initial begin
    int n;
    clear_all();
    repeat (3) @(negedge clk);
    chk("rst_sa_adr", {22'd0, sa_adr}, 32'd0);
    chk("rst_outs", {rom_req, lb_we, busy, ovf}, 32'd0);
    chk("rst_lb", {lb_wadr, lb_wdat, rom_adr}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // single sprite
    set_spr(0, 8'h10, 9'h020, 7'h12, 8'h05);
    run_line(8'h13, -1);
    chk("single_cnt", wr_seen, 14);
    chk("single_px0", lbuf[10'h220], 12'h121);
    chk("single_gap4", lbuf[10'h224], 12'hFFF);
    chk("single_gapC", lbuf[10'h22C], 12'hFFF);

    // terminator at slot 1 hides slot 2
    clear_all();
    set_spr(0, 8'h80, 9'h000, 7'h01, 8'h01);
    set_spr(2, 8'h10, 9'h050, 7'h02, 8'h02);
    run_line(8'h13, 5);
    chk("term_cnt", wr_seen, 0);

    // nine hitting sprites, only eight drawn
    clear_all();
    rom_mode = 1;
    ack_dly = 1;
    for (int k = 0; k < 9; k++) set_spr(k, 8'h10, 9'(k*40), 7'(k+3), 8'(k*7+1));
    run_line(8'h1F, -1);
    repeat (5) @(negedge clk);
    chk("ovf_hold", {31'd0, ovf}, 32'd1);
    run_line(8'h40, -1);

    // horizontal wrap
    clear_all();
    rom_mode = 0;
    ack_dly = 2;
    set_spr(0, 8'h00, 9'h1FC, 7'h0A, 8'h03);
    run_line(8'h05, -1);
    chk("wrap_1fc", lbuf[{exp_bank, 9'h1FC}], 12'h0A1);
    chk("wrap_000", lbuf[{exp_bank, 9'h000}], 12'hFFF);
    chk("wrap_001", lbuf[{exp_bank, 9'h001}], 12'h0A5);
    chk("wrap_00b", lbuf[{exp_bank, 9'h00B}], 12'h0A7);

    // overlap: higher index wins
    clear_all();
    set_spr(0, 8'h00, 9'h040, 7'h11, 8'h03);
    set_spr(1, 8'h00, 9'h044, 7'h22, 8'h04);
    run_line(8'h02, -1);
    chk("overlap_45", lbuf[{exp_bank, 9'h045}], 12'h222);
    chk("overlap_41", lbuf[{exp_bank, 9'h041}], 12'h112);

    // abort during FETCH, then a late ack
    clear_all();
    resp_en = 1'b0;
    set_spr(0, 8'h10, 9'h020, 7'h12, 8'h05);
    exp_bank = ~exp_bank;
    rq.push_back(13'h0A6);
    wr_seen = 0;
    @(negedge clk); vpos = 8'h13; line_start = 1'b1;
    @(negedge clk); line_start = 1'b0;
    n = 0;
    while (!rom_req && n < 100) begin @(negedge clk); n++; end
    chk("abort_req_seen", {31'd0, rom_req}, 32'd1);
    repeat (2) @(negedge clk);
    vpos = 8'h80; line_start = 1'b1; exp_bank = ~exp_bank;
    @(negedge clk); line_start = 1'b0;
    chk("abort_req_drop", {31'd0, rom_req}, 32'd0);
    chk("abort_sa_adr", {22'd0, sa_adr}, 32'd0);
    late_ack = 1'b1;
    wait_idle(n);
    chk("abort_no_wr", wr_seen, 0);
    chk("abort_rom_left", rq.size(), 0);
    resp_en = 1'b1;
    run_line(8'h13, -1);
    chk("abort_bank_wr", lbuf[{exp_bank, 9'h020}], 12'h121);

    // reset in the middle of DRAW
    exp_bank = ~exp_bank;
    void'(model_line(8'h13));
    @(negedge clk); vpos = 8'h13; line_start = 1'b1;
    @(negedge clk); line_start = 1'b0;
    n = 0;
    while (!lb_we && n < 200) begin @(negedge clk); n++; end
    chk("rst_draw_reached", {31'd0, lb_we}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_outs", {rom_req, lb_we, busy, ovf}, 32'd0);
    chk("midrst_adr", {lb_wadr, lb_wdat, rom_adr}, 32'd0);
    chk("midrst_sa", {22'd0, sa_adr}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    wq.delete(); rq.delete();
    exp_bank = 1'b0;
    repeat (10) @(negedge clk);
    chk("midrst_idle", {busy, rom_req, lb_we}, 32'd0);
    run_line(8'h13, -1);
    chk("midrst_bank1", lbuf[10'h220], 12'h121);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
